// File: rtl/stream_prefetch_pkg.sv
// Shared types and AXI constants for the stream prefetch buffer.
// Optional perf counters are enabled by defining STREAM_PREFETCH_PERF_EN.
package stream_prefetch_pkg;

  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spb_entry.sv
// One prefetch ring slot: tag, valid bit and a line of data words.
// Single-cycle word write; invalidate has priority over validate.
module spb_entry
  import stream_prefetch_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 27,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [31:0]             wr_dat_i,
  input  logic                    set_vld_i,
  input  logic [TAG_W-1:0]        set_tag_i,
  input  logic [TAG_W-1:0]        cmp_tag_i,
  output logic                    match_o,
  output logic [32*LINE_WORDS-1:0] line_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q [LINE_WORDS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (set_vld_i) begin
      valid_q <= 1'b1;
      tag_q   <= set_tag_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < LINE_WORDS; k++) data_q[k] <= '0;
    end else if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign match_o = valid_q && (tag_q == cmp_tag_i);

  always_comb begin
    line_o = '0;
    for (int k = 0; k < LINE_WORDS; k++) line_o[32*k +: 32] = data_q[k];
  end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential-line prefetch ring between cache refill and an AXI3 read port; hit lookup is combinational.
// Perf counters present only when STREAM_PREFETCH_PERF_EN is defined; one burst outstanding at most.
module stream_prefetch_buffer
  import stream_prefetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 8,
  parameter int AXI_ID     = 3,
  parameter int PAGE_BITS  = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     restart,
  input  logic [31:0]              restart_addr,
  input  logic [31:0]              lookup_addr,
  output logic                     hit,
  output logic [32*LINE_WORDS-1:0] hit_line,
  input  logic                     take,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
`ifdef STREAM_PREFETCH_PERF_EN
  ,
  output logic [31:0]              perf_hit_cnt,
  output logic [31:0]              perf_miss_cnt
`endif
);

  localparam int OFF_W  = clog2(LINE_WORDS) + 2;
  localparam int TAG_W  = 32 - OFF_W;
  localparam int PTR_W  = clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WIDX_W = clog2(LINE_WORDS);
  localparam int PG_W   = PAGE_BITS - OFF_W;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] next_line_q, next_line_d;
  logic             active_q, active_d, err_q, err_d;
  logic [WIDX_W-1:0] beat_q, beat_d;

  logic [DEPTH-1:0]          match, clear, wr_en, set_vld;
  logic [32*LINE_WORDS-1:0]  line [DEPTH];
  logic [TAG_W-1:0]          lookup_line, restart_line, next_line_inc;
  logic [PTR_W-1:0]          hit_idx;
  logic [CNT_W-1:0]          pop_n;
  logic take_fire, r_beat, r_last, d_last, beat_err, fill_ok;
  logic unused_addr_bits;

  assign lookup_line      = lookup_addr[31:OFF_W];
  assign restart_line     = restart_addr[31:OFF_W];
  assign next_line_inc    = next_line_q + TAG_W'(1);
  assign unused_addr_bits = ^{restart_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    spb_entry #(.LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .IDX_W(WIDX_W)) u_ent (
      .clk       (clk),
      .resetn    (resetn),
      .clear_i   (clear[i]),
      .wr_en_i   (wr_en[i]),
      .wr_idx_i  (beat_q),
      .wr_dat_i  (rdata),
      .set_vld_i (set_vld[i]),
      .set_tag_i (next_line_q),
      .cmp_tag_i (lookup_line),
      .match_o   (match[i]),
      .line_o    (line[i])
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        hit      = 1'b1;
        hit_idx  = PTR_W'(i);
        hit_line = hit_line | line[i];
      end
    end
  end

  // Popping runs from head through the hit slot inclusive.
  assign pop_n     = {1'b0, PTR_W'(hit_idx - head_q)} + CNT_W'(1);
  assign take_fire = take && hit && !restart;
  assign r_beat    = (state_q == R) && rvalid && (rid == 4'(AXI_ID));
  assign r_last    = r_beat && rlast;
  assign d_last    = (state_q == DRAIN) && rvalid && rlast && (rid == 4'(AXI_ID));
  assign beat_err  = (rresp != AXI_RESP_OKAY);
  assign fill_ok   = r_last && !restart && !err_q && !beat_err;

  always_comb begin
    clear   = '0;
    wr_en   = '0;
    set_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i]   = r_beat && (fill_q == PTR_W'(i));
      set_vld[i] = fill_ok && (fill_q == PTR_W'(i));
      clear[i]   = restart ||
                   (take_fire && ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < pop_n));
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    count_d     = count_q;
    next_line_d = next_line_q;
    active_d    = active_q;
    fill_d      = fill_q;
    beat_d      = beat_q;
    err_d       = err_q;

    if (take_fire) begin
      head_d  = head_q + pop_n[PTR_W-1:0];
      count_d = count_q - pop_n;
    end
    if (fill_ok) count_d = count_d + CNT_W'(1);

    case (state_q)
      IDLE: if (!restart && active_q && (count_q < CNT_W'(DEPTH))) begin
        state_d = AR;
        fill_d  = head_q + count_q[PTR_W-1:0];
      end
      AR: if (arready) begin
        state_d = restart ? DRAIN : R;
        beat_d  = '0;
        err_d   = 1'b0;
      end else if (restart) begin
        state_d = IDLE;
      end
      R: if (restart) begin
        state_d = r_last ? IDLE : DRAIN;
      end else if (r_beat) begin
        beat_d = beat_q + WIDX_W'(1);
        if (beat_err) err_d = 1'b1;
        if (rlast) begin
          state_d = IDLE;
          if (fill_ok) begin
            next_line_d = next_line_inc;
            if (next_line_inc[PG_W-1:0] == '0) active_d = 1'b0;
          end else begin
            active_d = 1'b0;
          end
        end
      end
      DRAIN: if (d_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (restart) begin
      head_d      = '0;
      count_d     = '0;
      next_line_d = restart_line + TAG_W'(1);
      active_d    = (restart_line[PG_W-1:0] != '1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      head_q      <= '0;
      count_q     <= '0;
      next_line_q <= '0;
      active_q    <= 1'b0;
      fill_q      <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      count_q     <= count_d;
      next_line_q <= next_line_d;
      active_q    <= active_d;
      fill_q      <= fill_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  assign arvalid = (state_q == AR);
  assign araddr  = {next_line_q, {OFF_W{1'b0}}};
  assign arid    = 4'(AXI_ID);
  assign arlen   = 4'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign rready  = (state_q == R) || (state_q == DRAIN);

`ifdef STREAM_PREFETCH_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (take_fire && (perf_hit_q != 32'hFFFF_FFFF)) perf_hit_q <= perf_hit_q + 32'd1;
      if (restart && (perf_miss_q != 32'hFFFF_FFFF)) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = perf_hit_q;
  assign perf_miss_cnt = perf_miss_q;
`endif

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed bench: AXI slave model plus scoreboards for AR addresses and hit probes.
module tb_stream_prefetch_buffer;

  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic            restart;
  logic [31:0]     restart_addr;
  logic [31:0]     lookup_addr;
  logic            hit;
  logic [32*LW-1:0] hit_line;
  logic            take;
  logic [3:0]      arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [3:0]      rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
`ifdef STREAM_PREFETCH_PERF_EN
  logic [31:0]     perf_hit_cnt, perf_miss_cnt;
`endif

  stream_prefetch_buffer #(.DEPTH(4), .LINE_WORDS(LW), .AXI_ID(3), .PAGE_BITS(12)) dut (
    .clk(clk), .resetn(resetn), .restart(restart), .restart_addr(restart_addr),
    .lookup_addr(lookup_addr), .hit(hit), .hit_line(hit_line), .take(take),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef STREAM_PREFETCH_PERF_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             h;
    logic [32*LW-1:0] line;
  } hexp_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] ar_exp [$];
  hexp_t       hit_exp [$];
  logic        probe = 1'b0;

  // Slave controls
  logic        slv_pause = 1'b0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;
  int          err_beat  = 0;
  logic [31:0] pend [$];
  int          sk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32*LW-1:0] exp_line(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int k = 0; k < LW; k++) l[32*k +: 32] = base + 32'(4*k);
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_restart(input logic [31:0] a);
    restart      = 1'b1;
    restart_addr = a;
    tick(1);
    restart      = 1'b0;
  endtask

  task automatic do_probe(input logic [31:0] a, input logic exp_h, input logic do_take);
    hexp_t e;
    e.h    = exp_h;
    e.line = exp_h ? exp_line({a[31:5], 5'b0}) : '0;
    hit_exp.push_back(e);
    lookup_addr = a;
    take        = do_take;
    probe       = 1'b1;
    tick(1);
    probe = 1'b0;
    take  = 1'b0;
  endtask

  // AXI read slave: zero-wait AR, back-to-back beats, data = byte address of each word.
  initial begin
    logic        ar_hs, r_hs;
    logic [31:0] ar_a;
    arready = 1'b1;
    rvalid  = 1'b0;
    rid     = 4'd3;
    rdata   = '0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      ar_a  = araddr;
      r_hs  = rvalid && rready;
      @(posedge clk);
      #1;
      if (!resetn) begin
        pend.delete();
        sk = 0;
      end else begin
        if (r_hs) begin
          if (sk == LW-1) begin
            void'(pend.pop_front());
            sk = 0;
          end else begin
            sk++;
          end
        end
        if (ar_hs) pend.push_back(ar_a);
      end
      rvalid = (pend.size() != 0) && !slv_pause;
      if (pend.size() != 0) begin
        rdata = pend[0] + 32'(4*sk);
        rlast = (sk == LW-1);
        rresp = (pend[0] == err_addr && sk == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rdata = '0;
        rlast = 1'b0;
        rresp = 2'b00;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents an AR or a probe is sampled.
  always @(negedge clk) begin
    if (resetn && arvalid && arready) begin
      if (ar_exp.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL ar_unexpected: got araddr %h expected no request", araddr);
      end else begin
        chk("ar_addr", araddr, ar_exp.pop_front());
        chk("ar_fields", {20'b0, arid, arlen, arsize, arburst}, {20'b0, 4'd3, 4'd7, 3'd2, 2'b01});
      end
    end
    if (probe) begin
      if (hit_exp.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL probe_unexpected: got hit %b expected no probe", hit);
      end else begin
        hexp_t e;
        e = hit_exp.pop_front();
        chk("probe_hit", {31'b0, hit}, {31'b0, e.h});
        n_checks++;
        if (hit_line !== e.line) begin
          n_err++;
          $display("FAIL probe_line @%h: got %h expected %h", lookup_addr, hit_line, e.line);
        end
      end
    end
  end

  initial begin
    int budget;
    resetn       = 1'b0;
    restart      = 1'b0;
    restart_addr = '0;
    lookup_addr  = '0;
    take         = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(1);

    // Reset state
    lookup_addr = 32'h0000_0000;
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_hit", {31'b0, hit}, 32'd0);
`ifdef STREAM_PREFETCH_PERF_EN
    chk("rst_perf_hit", perf_hit_cnt, 32'd0);
    chk("rst_perf_miss", perf_miss_cnt, 32'd0);
`endif

    // Reset in the middle of a burst
    slv_pause = 1'b1;
    ar_exp.push_back(32'h1000_0060);
    do_restart(32'h1000_0040);
    tick(5);
    chk("midburst_rready", {31'b0, rready}, 32'd1);
    resetn = 1'b0;
    tick(1);
    resetn    = 1'b1;
    slv_pause = 1'b0;
    tick(1);
    lookup_addr = 32'h1000_0060;
    chk("rst2_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst2_rready", {31'b0, rready}, 32'd0);
    chk("rst2_hit", {31'b0, hit}, 32'd0);

    // Sequential fill of four lines
    ar_exp.push_back(32'h1000_0060);
    ar_exp.push_back(32'h1000_0080);
    ar_exp.push_back(32'h1000_00A0);
    ar_exp.push_back(32'h1000_00C0);
    do_restart(32'h1000_0040);
    tick(80);
    chk("fill_idle_arvalid", {31'b0, arvalid}, 32'd0);
    chk("fill_ar_all_seen", ar_exp.size(), 32'd0);

    // Hit with take pops three lines, refill continues
    ar_exp.push_back(32'h1000_00E0);
    ar_exp.push_back(32'h1000_0100);
    ar_exp.push_back(32'h1000_0120);
    do_probe(32'h1000_00A4, 1'b1, 1'b1);
    do_probe(32'h1000_00C8, 1'b1, 1'b0);
    do_probe(32'h1000_0060, 1'b0, 1'b0);
    do_probe(32'h1000_00A0, 1'b0, 1'b0);
    tick(50);
    do_probe(32'h1000_0120, 1'b1, 1'b0);

    // Restart during beat 3 of a burst
    ar_exp.push_back(32'h1000_0220);
    do_restart(32'h1000_0200);
    budget = 40;
    while (!(rvalid && sk == 3 && pend.size() != 0 && pend[0] == 32'h1000_0220) && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("beat3_reached", {31'b0, (budget > 0)}, 32'd1);
    ar_exp.push_back(32'h1000_0320);
    ar_exp.push_back(32'h1000_0340);
    ar_exp.push_back(32'h1000_0360);
    ar_exp.push_back(32'h1000_0380);
    do_restart(32'h1000_0300);
    for (int b = 4; b < LW; b++) begin
      chk($sformatf("drain_rready_b%0d", b), {31'b0, rready}, 32'd1);
      tick(1);
    end
    tick(60);
    do_probe(32'h1000_0220, 1'b0, 1'b0);
    ar_exp.push_back(32'h1000_03A0);
    ar_exp.push_back(32'h1000_03C0);
    do_probe(32'h1000_0340, 1'b1, 1'b1);
    tick(40);
    do_probe(32'h1000_03C0, 1'b1, 1'b0);
    do_probe(32'h1000_0320, 1'b0, 1'b0);

    // Prefetch stops at the page boundary
    ar_exp.push_back(32'h1000_0FA0);
    ar_exp.push_back(32'h1000_0FC0);
    ar_exp.push_back(32'h1000_0FE0);
    do_restart(32'h1000_0F80);
    tick(60);
    do_probe(32'h1000_0FE0, 1'b1, 1'b0);
    chk("page_end_idle", {31'b0, arvalid}, 32'd0);
    do_restart(32'h1000_0FE0);
    tick(20);
    do_probe(32'h1000_0FA0, 1'b0, 1'b0);
    chk("last_line_no_ar", {31'b0, arvalid}, 32'd0);

    // Error response: line not validated, prefetch stops
    err_addr = 32'h1000_2020;
    err_beat = 2;
    ar_exp.push_back(32'h1000_2020);
    do_restart(32'h1000_2000);
    tick(40);
    do_probe(32'h1000_2020, 1'b0, 1'b0);
    chk("err_stop_arvalid", {31'b0, arvalid}, 32'd0);

`ifdef STREAM_PREFETCH_PERF_EN
    chk("perf_miss", perf_miss_cnt, 32'd6);
    chk("perf_hit", perf_hit_cnt, 32'd2);
`endif

    tick(5);
    chk("ar_queue_empty", ar_exp.size(), 32'd0);
    chk("probe_queue_empty", hit_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
